// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
// Handshake: a conversion is accepted on any rising edge where start=1 while
// the block is idle (busy=0 and the FSM in IDLE); start is ignored otherwise.
// done is a one-cycle pulse coinciding with the update of the digit outputs.
// The digits and overflow are held between conversions, so the display
// multiplexer never sees partial results.
module bin_to_bcd_seq #(
  parameter int BIN_WIDTH = 14
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [BIN_WIDTH-1:0] bin,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow,
  output logic [3:0]           ones,
  output logic [3:0]           tens,
  output logic [3:0]           hundreds,
  output logic [3:0]           thousands
);

  localparam int CW = $clog2(BIN_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // state is kept as a named signal so checkers can bind to it directly
  state_t               state;
  state_t               state_next;
  logic [BIN_WIDTH-1:0] shift_reg;
  logic [15:0]          scratch;
  logic [15:0]          scratch_adj;
  logic [CW-1:0]        cnt;
  logic                 ovf_flag;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // FSM next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (cnt == CW'(1)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // add-3 correction of every scratch nibble that is 5 or more, before the shift
  always_comb begin
    scratch_adj = scratch;
    for (int i = 0; i < 4; i++) begin
      if (scratch[4*i +: 4] >= 4'd5) scratch_adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
    end
  end

  // datapath: capture, shift, and publish the result on the DONE edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_reg <= '0;
      scratch   <= '0;
      cnt       <= '0;
      ovf_flag  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      overflow  <= 1'b0;
      ones      <= 4'd0;
      tens      <= 4'd0;
      hundreds  <= 4'd0;
      thousands <= 4'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            shift_reg <= bin;
            scratch   <= '0;
            cnt       <= CW'(BIN_WIDTH);
            ovf_flag  <= ({{(32-BIN_WIDTH){1'b0}}, bin} > 32'd9999);
            busy      <= 1'b1;
          end
        end
        SHIFT: begin
          scratch   <= {scratch_adj[14:0], shift_reg[BIN_WIDTH-1]};
          shift_reg <= {shift_reg[BIN_WIDTH-2:0], 1'b0};
          cnt       <= cnt - CW'(1);
          // a bit falling off the top of the scratch only happens above 9999;
          // folding it in keeps saturation correct even if the compare missed it
          ovf_flag  <= ovf_flag | scratch_adj[15];
        end
        DONE: begin
          if (ovf_flag) begin
            thousands <= 4'd9;
            hundreds  <= 4'd9;
            tens      <= 4'd9;
            ones      <= 4'd9;
            overflow  <= 1'b1;
          end else begin
            thousands <= scratch[15:12];
            hundreds  <= scratch[11:8];
            tens      <= scratch[7:4];
            ones      <= scratch[3:0];
            overflow  <= 1'b0;
          end
          done <= 1'b1;
          busy <= 1'b0;
        end
        default: begin
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq: default 14-bit instance plus an 8-bit one.
module tb_bin_to_bcd_seq;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 14-bit instance
  logic        start;
  logic [13:0] bin;
  logic        busy, done, overflow;
  logic [3:0]  ones, tens, hundreds, thousands;
  logic [15:0] bcd;
  assign bcd = {thousands, hundreds, tens, ones};

  bin_to_bcd_seq #(.BIN_WIDTH(14)) dut (
    .clk(clk), .rst(rst), .start(start), .bin(bin),
    .busy(busy), .done(done), .overflow(overflow),
    .ones(ones), .tens(tens), .hundreds(hundreds), .thousands(thousands)
  );

  // 8-bit instance
  logic        start8;
  logic [7:0]  bin8;
  logic        busy8, done8, ovf8;
  logic [3:0]  ones8, tens8, hund8, thou8;
  logic [15:0] bcd8;
  assign bcd8 = {thou8, hund8, tens8, ones8};

  bin_to_bcd_seq #(.BIN_WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .bin(bin8),
    .busy(busy8), .done(done8), .overflow(ovf8),
    .ones(ones8), .tens(tens8), .hundreds(hund8), .thousands(thou8)
  );

  // scoreboard state
  int          total = 0;
  int          bad   = 0;
  logic [15:0] prev_bcd = 16'h0000;
  logic        prev_ovf = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // one 14-bit conversion; called at a negedge, returns at the negedge where done=1
  // poke: re-pulse start at cycles 3 and 10 and change bin to 77 at cycle 2
  task automatic do_conv(input logic [13:0] v, input logic [15:0] exp_bcd,
                         input logic exp_ovf, input bit poke);
    start = 1'b1;
    bin   = v;
    @(posedge clk);
    for (int j = 0; j <= 15; j++) begin
      @(negedge clk);
      if (j < 15) begin
        check("busy_hi",  32'(busy), 32'd1);
        check("done_lo",  32'(done), 32'd0);
        check("bcd_hold", 32'(bcd), 32'(prev_bcd));
        check("ovf_hold", 32'(overflow), 32'(prev_ovf));
      end else begin
        check("done_hi", 32'(done), 32'd1);
        check("busy_lo", 32'(busy), 32'd0);
        check("digits",  32'(bcd), 32'(exp_bcd));
        check("ovf",     32'(overflow), 32'(exp_ovf));
      end
      if (j == 0) begin
        start = 1'b0;
        bin   = 14'($urandom_range(0, 16383));
      end
      if (poke) begin
        if (j == 2) bin = 14'd77;
        if (j == 3 || j == 10) start = 1'b1;
        if (j == 4 || j == 11) start = 1'b0;
      end
    end
    prev_bcd = exp_bcd;
    prev_ovf = exp_ovf;
  endtask

  // one 8-bit conversion with a bounded wait and a latency check
  task automatic conv8(input logic [7:0] v, input logic [15:0] exp_bcd);
    int n;
    start8 = 1'b1;
    bin8   = v;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    n = 0;
    while (!done8 && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("lat8",    32'(n), 32'd9);
    check("digits8", 32'(bcd8), 32'(exp_bcd));
    check("ovf8",    32'(ovf8), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; bin = '0; start8 = 1'b0; bin8 = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ovf",  32'(overflow), 32'd0);
    check("rst_bcd",  32'(bcd), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // zero, then back-to-back conversions
    do_conv(14'd0,     16'h0000, 1'b0, 1'b0);
    do_conv(14'd1234,  16'h1234, 1'b0, 1'b0);
    do_conv(14'd9999,  16'h9999, 1'b0, 1'b0);
    do_conv(14'd255,   16'h0255, 1'b0, 1'b0);
    do_conv(14'd10000, 16'h9999, 1'b1, 1'b0);
    do_conv(14'd16383, 16'h9999, 1'b1, 1'b0);
    do_conv(14'd42,    16'h0042, 1'b0, 1'b0);

    // start re-pulsed and bin changed mid-conversion
    do_conv(14'd500,   16'h0500, 1'b0, 1'b1);
    repeat (4) begin
      @(negedge clk);
      check("no_restart_busy", 32'(busy), 32'd0);
      check("no_restart_done", 32'(done), 32'd0);
      check("no_restart_bcd",  32'(bcd), 32'h0500);
    end

    // leave overflow and nines showing, then reset mid-conversion
    do_conv(14'd10000, 16'h9999, 1'b1, 1'b0);
    start = 1'b1; bin = 14'd8888;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_ovf",  32'(overflow), 32'd0);
    check("mid_rst_bcd",  32'(bcd), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    prev_bcd = 16'h0000;
    prev_ovf = 1'b0;
    @(negedge clk);
    do_conv(14'd31, 16'h0031, 1'b0, 1'b0);

    // narrow instance
    @(negedge clk);
    conv8(8'd200, 16'h0200);
    conv8(8'd9,   16'h0009);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
